tx_burst_gen: RTL and testbench
===============================

# tx_burst_gen

Generates the transmit tone burst that feeds the phased-delay shift-register chain (`pwm_in` of the delay stage). It replaces the external Arduino PWM with a square-wave carrier burst whose length and repetition are programmable. It also registers the beam-angle `select` code so that the angle can change only while the delay line is empty. This prevents a steering change from splitting a burst that is still in flight across two angles.

## Interface
Parameters:
- `HALF_PERIOD`, default 625: clocks per carrier half-period (625 gives 40 kHz at 50 MHz); must be ≥ 1.
- `FLUSH_CLKS`, default 8501: clocks needed to drain the delay chain after the last drive edge (one per tap, plus one).
- `SEL_W`, default 4: width of the beam-angle select code.

Ports:
- `clk` in 1: 50 MHz system clock.
- `rst_n` in 1: reset, **synchronous, active-low**.
- `start` in 1: request one burst; level-sampled, acted on only in IDLE.
- `cont` in 1: continuous mode; when high in IDLE, a burst starts without `start`.
- `n_cycles` in 8: carrier periods per burst; 0 means no burst.
- `gap_cycles` in 16: idle carrier periods between bursts in continuous mode.
- `sel_in` in SEL_W: requested beam-angle code (switches).
- `drive` out 1: carrier output to the delay chain input.
- `sel_out` out SEL_W: angle code to the delay-tap mux.
- `busy` out 1: high in BURST, DRAIN and GAP.
- `sync` out 1: one-cycle pulse on the first cycle of each burst (scope trigger).
- `done` out 1: one-cycle pulse after the drain completes.

## Operation
- States: IDLE, BURST, DRAIN, GAP.
- **IDLE**
  - `drive`=0 and `busy`=0; `sel_out`<=`sel_in` every cycle.
  - If (`start` | `cont`) and `n_cycles`≠0, go to BURST.
  - On that transition, latch `n_cycles` into `n_lat` and `gap_cycles` into `gap_lat`; clear the counters.
- **BURST**
  - `drive` is 1 on the first cycle.
  - Half-period counter `hcnt` runs 0..HALF_PERIOD-1 and then wraps.
  - On each wrap, `drive` toggles and half-period count `hp` increments.
  - When `hp` reaches 2·`n_lat` (9-bit compare), go to DRAIN with `drive`=0.
- **DRAIN**
  - `drive`=0; count FLUSH_CLKS clocks.
  - On the last DRAIN cycle: if `cont`=1 and `gap_lat`≠0, go to GAP; otherwise go to IDLE.
  - `done` pulses in the first cycle after DRAIN.
- **GAP**
  - `drive`=0; count `gap_lat`·2·HALF_PERIOD clocks, then go to IDLE.
  - GAP always completes, even if `cont` drops.
  - From IDLE, continuous mode restarts one cycle later. That IDLE cycle refreshes `sel_out`.
- **Ignored inputs**
  - `start` and `cont` are ignored outside IDLE.
  - `n_cycles`, `gap_cycles` and `sel_in` changes mid-burst have no effect until the next IDLE.
- **Reset**
  - `rst_n`=0 on any cycle (including mid-burst) forces IDLE on the next edge.
  - All counters clear; `drive`, `busy`, `sync` and `done` go to 0; `sel_out` goes to 0.
  - The delay chain is not flushed by this block.

## Timing
- All outputs are registered. Reset values: `drive`=0, `sel_out`=0, `busy`=0, `sync`=0, `done`=0.
- If `start` is high at edge t in IDLE:
  - `drive`, `sync` and `busy` are all 1 from t+1.
  - `sync` is low again at t+2.
- Burst length is exactly 2·N·HALF_PERIOD clocks, with each half-period exactly HALF_PERIOD clocks.
- DRAIN lasts exactly FLUSH_CLKS clocks. `busy` falls in the same cycle that `done` rises (IDLE case).
- Continuous-mode repetition period is 2·N·HALF_PERIOD + FLUSH_CLKS + G·2·HALF_PERIOD + 1 clocks, where the +1 is the IDLE cycle.
- `sel_out` updates only on IDLE edges, so it is stable from `sync` until `done`.
- Counter widths:
  - `hcnt`: $clog2(HALF_PERIOD).
  - `hp`: 9 bits.
  - Flush counter: $clog2(FLUSH_CLKS+1).
  - Gap counter: 16 + $clog2(2·HALF_PERIOD). No wrap-around is possible at maximum inputs.

## Structure
- Shared package `phased_pkg` holds:
  - the `burst_state_t` enum (IDLE, BURST, DRAIN, GAP);
  - `DEF_HALF_PERIOD`=625, `DEF_FLUSH_CLKS`=8501 and `SEL_W`=4, also used by the delay-line top.
- Single module, no sub-module. One shared down-counter is reused for the DRAIN and GAP durations.

## Test plan
All scenarios use HALF_PERIOD=4 and FLUSH_CLKS=10.
- **Single burst:** `start` pulse with N=3 → `sync` 1 cycle; `drive` runs 1111000011110000 11110000 (24 clocks); 10 clocks of 0; then `done` pulse; `busy` high for 34 cycles.
- **Zero cycles:** N=0 with `start` held → no `sync`, `drive` stays 0, `busy` stays 0.
- **Continuous mode:** `cont`=1, N=1, G=2 → `sync` pulses every 8+10+16+1=35 clocks. Dropping `cont` mid-GAP lets the GAP finish and then stays in IDLE.
- **Select gating:** `sel_in` changes 3→9 mid-BURST → `sel_out` stays 3 until the cycle after `done` and reads 9 the cycle after.
- **Reset mid-burst:** `rst_n`=0 for 1 cycle during BURST → next cycle `drive`=0, `busy`=0, `sel_out`=0, and the state is IDLE. A `start` afterwards gives a normal burst.
- **Ignored start:** `start` held high through an entire burst (`cont`=0) → a second burst begins one cycle after `done`. No `sync` occurs during BURST or DRAIN.

Source files
------------

// File: rtl/phased_pkg.sv
// Shared types and defaults for the phased-array transmit path.
// Used by the burst generator and by the delay-line top.
package phased_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        DRAIN,
        GAP
    } burst_state_t;

    localparam int DEF_HALF_PERIOD = 625;
    localparam int DEF_FLUSH_CLKS  = 8501;
    localparam int SEL_W           = 4;

endpackage

// File: rtl/tx_burst_gen.sv
// Square-wave carrier burst generator for the phased delay chain.
// It also gates the beam-select code so that it changes only while the chain is empty.
module tx_burst_gen
    import phased_pkg::*;
#(
    parameter int HALF_PERIOD = phased_pkg::DEF_HALF_PERIOD,
    parameter int FLUSH_CLKS  = phased_pkg::DEF_FLUSH_CLKS,
    parameter int SEL_W       = phased_pkg::SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cont,
    input  logic [7:0]       n_cycles,
    input  logic [15:0]      gap_cycles,
    input  logic [SEL_W-1:0] sel_in,
    output logic             drive,
    output logic [SEL_W-1:0] sel_out,
    output logic             busy,
    output logic             sync,
    output logic             done
);

    localparam int HW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int FW = $clog2(FLUSH_CLKS + 1);
    localparam int GW = 16 + $clog2(2 * HALF_PERIOD);
    localparam int CW = (FW > GW) ? FW : GW;

    localparam logic [HW-1:0] HCNT_LAST = HW'(HALF_PERIOD - 1);
    localparam logic [CW-1:0] FLUSH_LD  = CW'(FLUSH_CLKS - 1);
    localparam logic [CW-1:0] GAP_MUL   = CW'(2 * HALF_PERIOD);

    burst_state_t    state;
    logic [HW-1:0]   hcnt;
    logic [8:0]      hp;
    logic [8:0]      hp_inc;
    logic [7:0]      n_lat;
    logic [15:0]     gap_lat;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   gap_load;

    assign hp_inc   = hp + 9'd1;
    // Shared down-counter is loaded with length-1 so it ends on zero.
    assign gap_load = CW'(gap_lat) * GAP_MUL - CW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            hcnt    <= '0;
            hp      <= '0;
            n_lat   <= '0;
            gap_lat <= '0;
            cnt     <= '0;
            drive   <= 1'b0;
            sel_out <= '0;
            busy    <= 1'b0;
            sync    <= 1'b0;
            done    <= 1'b0;
        end else begin
            sync <= 1'b0;
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    sel_out <= sel_in;
                    drive   <= 1'b0;
                    busy    <= 1'b0;
                    if ((start | cont) && n_cycles != 8'd0) begin
                        state   <= BURST;
                        n_lat   <= n_cycles;
                        gap_lat <= gap_cycles;
                        hcnt    <= '0;
                        hp      <= '0;
                        cnt     <= '0;
                        drive   <= 1'b1;
                        busy    <= 1'b1;
                        sync    <= 1'b1;
                    end
                end
                BURST: begin
                    if (hcnt == HCNT_LAST) begin
                        hcnt <= '0;
                        hp   <= hp_inc;
                        if (hp_inc == {n_lat, 1'b0}) begin
                            state <= DRAIN;
                            drive <= 1'b0;
                            cnt   <= FLUSH_LD;
                        end else begin
                            drive <= ~drive;
                        end
                    end else begin
                        hcnt <= hcnt + HW'(1);
                    end
                end
                DRAIN: begin
                    drive <= 1'b0;
                    if (cnt == '0) begin
                        done <= 1'b1;
                        if (cont && gap_lat != 16'd0) begin
                            state <= GAP;
                            cnt   <= gap_load;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                GAP: begin
                    drive <= 1'b0;
                    if (cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_burst_gen.sv
// Directed self-checking bench for tx_burst_gen.
// Uses HALF_PERIOD=4 and FLUSH_CLKS=10.
module tb_tx_burst_gen;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        cont;
    logic [7:0]  n_cycles;
    logic [15:0] gap_cycles;
    logic [3:0]  sel_in;
    logic        drive;
    logic [3:0]  sel_out;
    logic        busy;
    logic        sync;
    logic        done;

    int checks;
    int failures;

    tx_burst_gen #(
        .HALF_PERIOD(4),
        .FLUSH_CLKS (10),
        .SEL_W      (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cont      (cont),
        .n_cycles  (n_cycles),
        .gap_cycles(gap_cycles),
        .sel_in    (sel_in),
        .drive     (drive),
        .sel_out   (sel_out),
        .busy      (busy),
        .sync      (sync),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        cont       = 1'b0;
        n_cycles   = 8'd0;
        gap_cycles = 16'd0;
        sel_in     = 4'd5;
        tick();
        tick();
        check("rst_drive", 32'(drive), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sync", 32'(sync), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sel", 32'(sel_out), 32'd0);
        rst_n = 1'b1;

        // single burst N=3 with sel change mid-burst
        sel_in   = 4'd3;
        n_cycles = 8'd3;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 34; i++) begin
            if (i == 5) sel_in = 4'd9;
            check("sb_drive", 32'(drive),
                  32'((i < 24) && ((i / 4) % 2 == 0)));
            check("sb_busy", 32'(busy), 32'd1);
            check("sb_sync", 32'(sync), 32'(i == 0));
            check("sb_done", 32'(done), 32'd0);
            check("sb_sel", 32'(sel_out), 32'd3);
            tick();
        end
        check("sb_done_pulse", 32'(done), 32'd1);
        check("sb_busy_fall", 32'(busy), 32'd0);
        check("sb_sel_hold", 32'(sel_out), 32'd3);
        tick();
        check("sb_done_low", 32'(done), 32'd0);
        check("sb_sel_new", 32'(sel_out), 32'd9);

        // zero cycles
        n_cycles = 8'd0;
        start    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("z_sync", 32'(sync), 32'd0);
            check("z_drive", 32'(drive), 32'd0);
            check("z_busy", 32'(busy), 32'd0);
        end
        start = 1'b0;

        // continuous mode N=1 G=2, period 35
        n_cycles   = 8'd1;
        gap_cycles = 16'd2;
        cont       = 1'b1;
        tick();
        check("c_sync0", 32'(sync), 32'd1);
        for (int i = 1; i <= 35; i++) begin
            tick();
            check("c_sync", 32'(sync), 32'(i == 35));
            if (i == 18) check("c_done", 32'(done), 32'd1);
            if (i == 18) check("c_busy_gap", 32'(busy), 32'd1);
            if (i == 34) check("c_busy_idle", 32'(busy), 32'd0);
        end
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 20) cont = 1'b0;
            check("c2_sync", 32'(sync), 32'd0);
            check("c2_busy", 32'(busy), 32'(i < 34));
        end

        // reset mid-burst
        n_cycles = 8'd3;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("r_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("r_drive", 32'(drive), 32'd0);
        check("r_busy", 32'(busy), 32'd0);
        check("r_sel", 32'(sel_out), 32'd0);
        check("r_sync", 32'(sync), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("r2_sync", 32'(sync), 32'd1);
        check("r2_drive", 32'(drive), 32'd1);
        check("r2_sel", 32'(sel_out), 32'd9);
        for (int i = 0; i < 34; i++) begin
            check("r2_busy", 32'(busy), 32'd1);
            tick();
        end
        check("r2_done", 32'(done), 32'd1);

        // start held through a burst
        n_cycles = 8'd1;
        start    = 1'b1;
        tick();
        check("h_sync0", 32'(sync), 32'd1);
        for (int i = 1; i <= 18; i++) begin
            tick();
            check("h_sync", 32'(sync), 32'd0);
            if (i == 18) check("h_done", 32'(done), 32'd1);
        end
        tick();
        check("h_sync2", 32'(sync), 32'd1);
        check("h_drive2", 32'(drive), 32'd1);
        start = 1'b0;
        for (int i = 1; i <= 18; i++) tick();
        check("h_done2", 32'(done), 32'd1);
        tick();
        check("h_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
